// File: rtl/lc3b_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : lc3b_mem_responder
// Purpose  : Memory-side responder for the LC-3b mem_read/mem_write/mem_resp
//            bus. It backs the bus with an internal array of 16-bit words,
//            answers every request after a fixed, programmable latency,
//            supports byte-enabled writes, and raises a sticky flag when
//            read and write are requested together.
// Ports    : clk             - system clock, rising edge
//            reset           - asynchronous, active-high reset
//            mem_address     - byte address (bit 0 ignored, upper bits alias)
//            mem_read        - read request level, held until mem_resp
//            mem_write       - write request level, held until mem_resp
//            mem_wdata       - write data
//            mem_byte_enable - [0] low byte, [1] high byte
//            mem_resp        - one-cycle completion pulse
//            mem_rdata       - last read data, held until the next read ends
//            proto_err       - sticky, read and write seen together
// Revision : 1.0 - initial release
// ============================================================================
module lc3b_mem_responder #(
    parameter int DEPTH_LOG2 = 8,   // log2 of the number of 16-bit words
    parameter int LATENCY    = 3    // acceptance edge to mem_resp, 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mem_address,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_wdata,
    input  logic [1:0]  mem_byte_enable,
    output logic        mem_resp,
    output logic [15:0] mem_rdata,
    output logic        proto_err
);

    localparam int         c_DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] c_LAT_LOAD = 4'(LATENCY - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    // Registered state
    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic [DEPTH_LOG2-1:0] r_addr;
    logic [15:0]           r_wdata;
    logic [1:0]            r_be;
    logic                  r_is_write;
    logic [15:0]           r_rdata;
    logic                  r_proto_err;

    // Storage; intentionally outside the reset domain so reset never
    // disturbs its contents.
    logic [15:0]           r_mem [0:c_DEPTH-1];

    // Combinational
    logic [1:0]            w_next_state;
    logic                  w_accept;
    logic                  w_done;
    logic                  w_mem_we;

    // Bit 0 and the bits above the word index are deliberately ignored,
    // which gives odd-address and wrap-around aliasing.
    logic                  w_addr_unused;
    assign w_addr_unused = ^{mem_address[15:DEPTH_LOG2+1], mem_address[0]};

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        mem_resp     = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (mem_read || mem_write) begin
                    w_accept     = 1'b1;
                    w_next_state = c_WAIT;
                end
            end
            c_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_done       = 1'b1;
                    w_next_state = c_RESP;
                end
            end
            c_RESP: begin
                // Requests are not sampled here; the requester drops them
                // on the edge that leaves this state.
                mem_resp     = 1'b1;
                w_next_state = c_IDLE;
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // A reset landing on the completing edge must suppress the write,
    // so the array enable is qualified with reset directly.
    assign w_mem_we = w_done && r_is_write && !reset;

    // ------------------------------------------------------------------
    // Control and capture registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_cnt       <= 4'd0;
            r_addr      <= '0;
            r_wdata     <= 16'h0000;
            r_be        <= 2'b00;
            r_is_write  <= 1'b0;
            r_rdata     <= 16'h0000;
            r_proto_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_addr     <= mem_address[DEPTH_LOG2:1];
                r_wdata    <= mem_wdata;
                r_be       <= mem_byte_enable;
                // Simultaneous read and write is resolved as a write.
                r_is_write <= mem_write;
                r_cnt      <= c_LAT_LOAD;
                if (mem_read && mem_write) begin
                    r_proto_err <= 1'b1;
                end
            end else if (r_state == c_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_done && !r_is_write) begin
                r_rdata <= r_mem[r_addr];
            end
        end
    end

    // ------------------------------------------------------------------
    // Byte-enabled array write
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            if (r_be[0]) begin
                r_mem[r_addr][7:0] <= r_wdata[7:0];
            end
            if (r_be[1]) begin
                r_mem[r_addr][15:8] <= r_wdata[15:8];
            end
        end
    end

    assign mem_rdata = r_rdata;
    assign proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_lc3b_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3b_mem_responder
// Purpose  : Directed self-checking bench for lc3b_mem_responder using the
//            default parameters (256 words, LATENCY = 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc3b_mem_responder;

    logic        clk;
    logic        reset;
    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_byte_enable;
    logic        mem_resp;
    logic [15:0] mem_rdata;
    logic        proto_err;

    int checks = 0;
    int errors = 0;

    lc3b_mem_responder #(
        .DEPTH_LOG2 (8),
        .LATENCY    (3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .proto_err       (proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete bus transaction. Entered and left on a falling edge with
    // the DUT idle. Checks latency, read data at the pulse and pulse width.
    task automatic access(input string tag, input logic [15:0] addr,
                          input logic rd, input logic wr,
                          input logic [15:0] wd, input logic [1:0] be,
                          input logic [15:0] exp_rdata);
        int n;
        mem_address     = addr;
        mem_read        = rd;
        mem_write       = wr;
        mem_wdata       = wd;
        mem_byte_enable = be;
        @(posedge clk);               // acceptance edge E0
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (mem_resp) break;
        end
        chk({tag, "_latency"}, 16'(n), 16'd3);
        chk({tag, "_rdata"}, mem_rdata, exp_rdata);
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_pulse_end"}, {15'd0, mem_resp}, 16'd0);
        @(negedge clk);
    endtask

    initial begin
        reset           = 1'b1;
        mem_address     = 16'h0000;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_wdata       = 16'h0000;
        mem_byte_enable = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_resp",  {15'd0, mem_resp},  16'd0);
        chk("rst_rdata", mem_rdata,          16'h0000);
        chk("rst_perr",  {15'd0, proto_err}, 16'd0);
        reset = 1'b0;
        @(negedge clk);

        // Full-word write then read back
        access("wr_beef", 16'h0010, 1'b0, 1'b1, 16'hBEEF, 2'b11, 16'h0000);
        access("rd_beef", 16'h0010, 1'b1, 1'b0, 16'h0000, 2'b00, 16'hBEEF);

        // Byte enables; writes never disturb mem_rdata
        access("wr_1234", 16'h0020, 1'b0, 1'b1, 16'h1234, 2'b11, 16'hBEEF);
        access("wr_hi",   16'h0020, 1'b0, 1'b1, 16'hAB00, 2'b10, 16'hBEEF);
        access("rd_ab34", 16'h0020, 1'b1, 1'b0, 16'h0000, 2'b00, 16'hAB34);
        access("wr_be00", 16'h0020, 1'b0, 1'b1, 16'hFFFF, 2'b00, 16'hAB34);
        access("rd_be00", 16'h0020, 1'b1, 1'b0, 16'h0000, 2'b00, 16'hAB34);
        access("wr_lo",   16'h0021, 1'b0, 1'b1, 16'h00CD, 2'b01, 16'hAB34);
        access("rd_abcd", 16'h0020, 1'b1, 1'b0, 16'h0000, 2'b00, 16'hABCD);

        // Aliasing: wrap above the array and odd byte address
        access("wr_alias", 16'h0202, 1'b0, 1'b1, 16'h5A5A, 2'b11, 16'hABCD);
        access("rd_alias", 16'h0002, 1'b1, 1'b0, 16'h0000, 2'b00, 16'h5A5A);
        access("rd_odd",   16'h0003, 1'b1, 1'b0, 16'h0000, 2'b00, 16'h5A5A);

        // Continuous read: a pulse every 5 cycles, data stable between them
        mem_address = 16'h0010;
        mem_read    = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("cont_resp_%0d", k), {15'd0, mem_resp},
                ((k % 5) == 3) ? 16'd1 : 16'd0);
            chk($sformatf("cont_rdata_%0d", k), mem_rdata,
                (k < 3) ? 16'h5A5A : 16'hBEEF);
        end
        @(negedge clk);
        mem_read = 1'b0;
        @(negedge clk);

        // Read and write together: resolved as a write, sticky flag
        access("both", 16'h0004, 1'b1, 1'b1, 16'h00C3, 2'b11, 16'hBEEF);
        chk("perr_set", {15'd0, proto_err}, 16'd1);
        access("rd_00c3", 16'h0004, 1'b1, 1'b0, 16'h0000, 2'b00, 16'h00C3);
        chk("perr_sticky", {15'd0, proto_err}, 16'd1);

        // Reset during WAIT discards the pending write
        access("wr_1111", 16'h0008, 1'b0, 1'b1, 16'h1111, 2'b11, 16'h00C3);
        mem_address     = 16'h0008;
        mem_write       = 1'b1;
        mem_wdata       = 16'h7777;
        mem_byte_enable = 2'b11;
        @(posedge clk);               // accepted
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_resp",  {15'd0, mem_resp},  16'd0);
        chk("arst_rdata", mem_rdata,          16'h0000);
        chk("arst_perr",  {15'd0, proto_err}, 16'd0);
        mem_write = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        begin
            int seen;
            seen = 0;
            repeat (6) begin
                @(posedge clk);
                #1;
                if (mem_resp) seen++;
            end
            chk("arst_no_resp", 16'(seen), 16'd0);
        end
        @(negedge clk);
        access("rd_1111", 16'h0008, 1'b1, 1'b0, 16'h0000, 2'b00, 16'h1111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
